// File: rtl/vcm_i2c_target.sv
// I2C target emulating a DW9714-class VCM driver: latches the two-byte focus word, reads it back.
// SCL/SDA are oversampled on CLK_50; SDA drive is open-drain and only changes after an SCL fall.
module vcm_i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h0C
) (
    input  logic        CLK_50,
    input  logic        RESET_N,
    input  logic        SCL,
    inout  wire         SDA,
    output logic [15:0] VCM_DATA,
    output logic [9:0]  POSITION,
    output logic        POWER_DOWN,
    output logic        VCM_VALID,
    output logic        BUSY
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_MACK, S_IGNORE
    } state_t;

    logic scl_s1_q, scl_s2_q, scl_h_q, sda_s1_q, sda_s2_q, sda_h_q;
    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d, hi_q, hi_d, lo_q, lo_d;
    logic [15:0] vcm_q, vcm_d;
    logic        vld_q, vld_d, busy_q, busy_d, oe_q, oe_d;
    logic        scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]  new_byte, rd_nxt;

    // Idle-bus reset value (both lines high) so releasing reset creates no false edge.
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            {scl_s1_q, scl_s2_q, scl_h_q} <= 3'b111;
            {sda_s1_q, sda_s2_q, sda_h_q} <= 3'b111;
        end else begin
            {scl_s1_q, scl_s2_q, scl_h_q} <= {SCL, scl_s1_q, scl_s2_q};
            {sda_s1_q, sda_s2_q, sda_h_q} <= {SDA, sda_s1_q, sda_s2_q};
        end
    end

    assign scl_rise  = scl_s2_q & ~scl_h_q;
    assign scl_fall  = ~scl_s2_q & scl_h_q;
    assign start_det = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
    assign new_byte  = {shift_q[6:0], sda_s2_q};
    // idx_q[0] names the byte just sent on a read; the next one is the other half.
    assign rd_nxt    = idx_q[0] ? vcm_q[15:8] : vcm_q[7:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        vcm_d   = vcm_q;
        vld_d   = 1'b0;
        busy_d  = busy_q;
        oe_d    = oe_q;
        if (stop_det) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (start_det) begin
            state_d = S_ADDR;
            cnt_d   = 3'd0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: if (scl_rise) begin
                    shift_d = new_byte;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        busy_d  = (new_byte[7:1] == DEV_ADDR);
                        state_d = (new_byte[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_IGNORE;
                    end
                end
                // cnt_q is the ACK phase: 0 = drive on this fall, 1 = release on the 9th fall.
                S_ADDR_ACK: if (scl_fall) begin
                    if (cnt_q == 3'd0) begin
                        oe_d  = 1'b1;
                        cnt_d = 3'd1;
                    end else begin
                        cnt_d = 3'd0;
                        idx_d = 2'd0;
                        if (shift_q[0]) begin
                            state_d = S_RD_BYTE;
                            oe_d    = ~vcm_q[15];
                            shift_d = {vcm_q[14:8], 1'b0};
                        end else begin
                            state_d = S_WR_BYTE;
                            oe_d    = 1'b0;
                        end
                    end
                end
                S_WR_BYTE: if (scl_rise) begin
                    shift_d = new_byte;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = S_WR_ACK;
                        if (idx_q == 2'd0) hi_d = new_byte;
                        if (idx_q == 2'd1) lo_d = new_byte;
                    end
                end
                S_WR_ACK: if (scl_fall) begin
                    if (cnt_q == 3'd0) begin
                        if (idx_q[1]) begin
                            state_d = S_IGNORE;
                            oe_d    = 1'b0;
                        end else begin
                            oe_d  = 1'b1;
                            cnt_d = 3'd1;
                            if (idx_q == 2'd1) begin
                                vcm_d = {hi_q, lo_q};
                                vld_d = 1'b1;
                            end
                        end
                    end else begin
                        oe_d    = 1'b0;
                        cnt_d   = 3'd0;
                        idx_d   = idx_q + 2'd1;
                        state_d = S_WR_BYTE;
                    end
                end
                S_RD_BYTE: begin
                    if (scl_fall) begin
                        oe_d    = ~shift_q[7];
                        shift_d = {shift_q[6:0], 1'b0};
                    end else if (scl_rise) begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) state_d = S_RD_MACK;
                    end
                end
                // Phases: 0 = release on 8th fall, 1 = sample initiator ACK, 2 = next byte on 9th fall.
                S_RD_MACK: begin
                    if (scl_fall && cnt_q == 3'd0) begin
                        oe_d  = 1'b0;
                        cnt_d = 3'd1;
                    end else if (scl_rise && cnt_q == 3'd1) begin
                        if (sda_s2_q) state_d = S_IGNORE;
                        else          cnt_d   = 3'd2;
                    end else if (scl_fall && cnt_q == 3'd2) begin
                        idx_d   = {1'b0, ~idx_q[0]};
                        oe_d    = ~rd_nxt[7];
                        shift_d = {rd_nxt[6:0], 1'b0};
                        cnt_d   = 3'd0;
                        state_d = S_RD_BYTE;
                    end
                end
                S_IGNORE: oe_d = 1'b0;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            idx_q   <= 2'd0;
            shift_q <= 8'h00;
            hi_q    <= 8'h00;
            lo_q    <= 8'h00;
            vcm_q   <= 16'h0000;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            vcm_q   <= vcm_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            oe_q    <= oe_d;
        end
    end

    assign SDA        = oe_q ? 1'b0 : 1'bz;
    assign VCM_DATA   = vcm_q;
    assign POSITION   = vcm_q[13:4];
    assign POWER_DOWN = vcm_q[15];
    assign VCM_VALID  = vld_q;
    assign BUSY       = busy_q;
endmodule

// File: tb/tb_vcm_i2c_target.sv
// Bench for vcm_i2c_target: bit-banged I2C initiator, open-drain bus with pull-up, transaction-level model.
module tb_vcm_i2c_target;
    localparam int Q = 8;

    logic        CLK_50 = 1'b0;
    logic        RESET_N = 1'b0;
    logic        SCL = 1'b1;
    logic        m_low = 1'b0;
    wire         SDA;
    logic [15:0] VCM_DATA;
    logic [9:0]  POSITION;
    logic        POWER_DOWN, VCM_VALID, BUSY;

    pullup (SDA);
    assign SDA = m_low ? 1'b0 : 1'bz;

    vcm_i2c_target #(.DEV_ADDR(7'h0C)) dut (
        .CLK_50(CLK_50), .RESET_N(RESET_N), .SCL(SCL), .SDA(SDA),
        .VCM_DATA(VCM_DATA), .POSITION(POSITION), .POWER_DOWN(POWER_DOWN),
        .VCM_VALID(VCM_VALID), .BUSY(BUSY)
    );

    always #10 CLK_50 = ~CLK_50;

    int n_chk = 0, n_fail = 0;
    logic [15:0] exp_vcm = 16'h0000;
    int exp_vld = 0;

    // Passive bus monitors, sampled away from the active edge.
    int vld_hi = 0, vld_rise = 0, dut_low_cyc = 0, busy_cyc = 0;
    logic vld_prev = 1'b0;
    logic [15:0] vld_dat = 16'h0;
    always @(negedge CLK_50) begin
        if (VCM_VALID) begin
            vld_hi  = vld_hi + 1;
            vld_dat = VCM_DATA;
            if (!vld_prev) vld_rise = vld_rise + 1;
        end
        vld_prev = VCM_VALID;
        if (SDA === 1'b0 && !m_low) dut_low_cyc = dut_low_cyc + 1;
        if (BUSY) busy_cyc = busy_cyc + 1;
    end

    task automatic wq();
        repeat (Q) @(posedge CLK_50);
        #2;
    endtask

    task automatic i2c_start();
        m_low = 1'b0; wq(); SCL = 1'b1; wq(); m_low = 1'b1; wq(); SCL = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; wq(); SCL = 1'b1; wq(); m_low = 1'b0; wq(); wq();
    endtask

    task automatic put_bit(input logic b);
        m_low = ~b; wq(); SCL = 1'b1; wq(); wq(); SCL = 1'b0; wq();
    endtask

    task automatic get_bit(output logic b);
        m_low = 1'b0; wq(); SCL = 1'b1; wq(); b = (SDA === 1'b0) ? 1'b0 : 1'b1; wq(); SCL = 1'b0; wq();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(b);
        ack = ~b;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(~mack);
    endtask

    // Sends address byte plus n data bytes (data[23:16] first); acks[0] is the address ACK.
    task automatic write_txn(input logic [7:0] ab, input int n, input logic [23:0] data,
                             input bit do_stop, output logic [3:0] acks);
        logic a;
        acks = 4'b0;
        i2c_start();
        send_byte(ab, a); acks[0] = a;
        for (int i = 0; i < n; i++) begin
            send_byte(data[23-8*i -: 8], a);
            acks[i+1] = a;
        end
        if (do_stop) i2c_stop();
    endtask

    // Reads n bytes (into bytes[31:24] first), ACKing all but the last; reports SDA release after the NACK.
    task automatic read_txn(input int n, output logic addr_ack, output logic [31:0] bytes,
                            output logic released);
        logic [7:0] d;
        bytes = 32'h0;
        i2c_start();
        send_byte(8'h19, addr_ack);
        for (int k = 0; k < n; k++) begin
            recv_byte(k < n - 1, d);
            bytes[31-8*k -: 8] = d;
        end
        m_low = 1'b0; wq();
        released = (SDA === 1'b1);
        i2c_stop();
    endtask

    // Transaction-level model of a write: expected ACK pattern and commit effect.
    function automatic logic [3:0] model_write(input logic [7:0] ab, input int n, input logic [23:0] data);
        logic [3:0] e;
        logic match;
        match = (ab[7:1] == 7'h0C) && !ab[0];
        e = 4'b0;
        e[0] = match;
        for (int i = 0; i < n; i++) e[i+1] = match && (i < 2);
        if (match && n >= 2) begin
            exp_vcm = data[23:8];
            exp_vld = exp_vld + 1;
        end
        return e;
    endfunction

    function automatic logic [31:0] model_read(input int n);
        logic [31:0] r;
        r = 32'h0;
        for (int k = 0; k < n; k++) r[31-8*k -: 8] = (k % 2 == 0) ? exp_vcm[15:8] : exp_vcm[7:0];
        return r;
    endfunction

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (5) @(posedge CLK_50);
        #2;
        n_chk++; if (VCM_DATA !== 16'h0000) begin n_fail++; $display("FAIL reset_vcm: got %h want 0000", VCM_DATA); end
        n_chk++; if ({POSITION, POWER_DOWN, VCM_VALID, BUSY} !== 13'b0) begin n_fail++; $display("FAIL reset_outs: got pos=%h pd=%b vld=%b busy=%b want 0", POSITION, POWER_DOWN, VCM_VALID, BUSY); end
        n_chk++; if (SDA !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b want released(1)", SDA); end
        RESET_N = 1'b1;
        wq();
    endtask

    task automatic test_basic_write();
        logic [3:0] acks, e;
        int r0, h0, b0;
        r0 = vld_rise; h0 = vld_hi; b0 = busy_cyc;
        e = model_write(8'h18, 2, 24'h0FF000);
        write_txn(8'h18, 2, 24'h0FF000, 1'b1, acks);
        n_chk++; if (acks[2:0] !== e[2:0] || e[2:0] !== 3'b111) begin n_fail++; $display("FAIL basic_acks: got %b want 111", acks[2:0]); end
        n_chk++; if (VCM_DATA !== 16'h0FF0) begin n_fail++; $display("FAIL basic_vcm: got %h want 0ff0", VCM_DATA); end
        n_chk++; if (POSITION !== 10'h0FF || POWER_DOWN !== 1'b0) begin n_fail++; $display("FAIL basic_pos: got pos=%h pd=%b want 0ff/0", POSITION, POWER_DOWN); end
        n_chk++; if (vld_rise - r0 != 1 || vld_hi - h0 != 1) begin n_fail++; $display("FAIL basic_valid: got pulses=%0d cycles=%0d want 1/1", vld_rise - r0, vld_hi - h0); end
        n_chk++; if (vld_dat !== 16'h0FF0) begin n_fail++; $display("FAIL basic_valid_data: got %h want 0ff0", vld_dat); end
        n_chk++; if (busy_cyc == b0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got cycles=%0d now=%b want >0 and 0", busy_cyc - b0, BUSY); end
    endtask

    task automatic test_wrong_addr();
        logic [3:0] acks, e;
        int r0, l0, b0;
        r0 = vld_rise; l0 = dut_low_cyc; b0 = busy_cyc;
        e = model_write(8'h1A, 2, 24'h123400);
        write_txn(8'h1A, 2, 24'h123400, 1'b1, acks);
        n_chk++; if (acks[2:0] !== e[2:0]) begin n_fail++; $display("FAIL wrong_acks: got %b want %b", acks[2:0], e[2:0]); end
        n_chk++; if (dut_low_cyc != l0) begin n_fail++; $display("FAIL wrong_sda: got %0d low cycles want 0", dut_low_cyc - l0); end
        n_chk++; if (VCM_DATA !== exp_vcm) begin n_fail++; $display("FAIL wrong_vcm: got %h want %h", VCM_DATA, exp_vcm); end
        n_chk++; if (vld_rise != r0 || busy_cyc != b0) begin n_fail++; $display("FAIL wrong_side: got pulses=%0d busy=%0d want 0/0", vld_rise - r0, busy_cyc - b0); end
    endtask

    task automatic test_read_back();
        logic aa, rel;
        logic [31:0] got;
        read_txn(4, aa, got, rel);
        n_chk++; if (aa !== 1'b1) begin n_fail++; $display("FAIL read_addr_ack: got %b want 1", aa); end
        n_chk++; if (got !== model_read(4) || got !== 32'h0FF00FF0) begin n_fail++; $display("FAIL read_data: got %h want 0ff00ff0", got); end
        n_chk++; if (rel !== 1'b1) begin n_fail++; $display("FAIL read_release: got %b want 1", rel); end
    endtask

    task automatic test_trunc_overlong();
        logic [3:0] acks, e;
        int r0;
        r0 = vld_rise;
        e = model_write(8'h18, 1, 24'h800000);
        write_txn(8'h18, 1, 24'h800000, 1'b1, acks);
        n_chk++; if (acks[1:0] !== e[1:0]) begin n_fail++; $display("FAIL trunc_acks: got %b want %b", acks[1:0], e[1:0]); end
        n_chk++; if (VCM_DATA !== 16'h0FF0 || vld_rise != r0) begin n_fail++; $display("FAIL trunc_vcm: got %h pulses=%0d want 0ff0/0", VCM_DATA, vld_rise - r0); end
        e = model_write(8'h18, 3, 24'h801055);
        write_txn(8'h18, 3, 24'h801055, 1'b1, acks);
        n_chk++; if (acks !== e || acks !== 4'b0111) begin n_fail++; $display("FAIL over_acks: got %b want 0111", acks); end
        n_chk++; if (VCM_DATA !== 16'h8010 || POWER_DOWN !== 1'b1 || POSITION !== 10'h001) begin n_fail++; $display("FAIL over_vcm: got %h pd=%b pos=%h want 8010/1/001", VCM_DATA, POWER_DOWN, POSITION); end
    endtask

    task automatic test_repeated_start();
        logic [3:0] acks, e;
        logic aa, rel;
        logic [31:0] got;
        e = model_write(8'h18, 2, 24'h012300);
        write_txn(8'h18, 2, 24'h012300, 1'b0, acks);
        n_chk++; if (acks[2:0] !== e[2:0] || VCM_DATA !== 16'h0123) begin n_fail++; $display("FAIL rs_write: got acks=%b vcm=%h want 111/0123", acks[2:0], VCM_DATA); end
        read_txn(2, aa, got, rel);
        n_chk++; if (aa !== 1'b1 || got[31:16] !== 16'h0123) begin n_fail++; $display("FAIL rs_read: got ack=%b data=%h want 1/0123", aa, got[31:16]); end
    endtask

    task automatic test_reset_mid_ack();
        logic [3:0] acks, e;
        logic [7:0] ab;
        ab = 8'h18;
        i2c_start();
        for (int i = 7; i >= 0; i--) put_bit(ab[i]);
        m_low = 1'b0; wq();
        n_chk++; if (SDA !== 1'b0 || BUSY !== 1'b1) begin n_fail++; $display("FAIL rst_pre_ack: got sda=%b busy=%b want 0/1", SDA, BUSY); end
        RESET_N = 1'b0;
        #1;
        n_chk++; if (SDA !== 1'b1) begin n_fail++; $display("FAIL rst_sda: got %b want released(1)", SDA); end
        n_chk++; if (VCM_DATA !== 16'h0 || BUSY !== 1'b0 || VCM_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_outs: got vcm=%h busy=%b vld=%b want 0", VCM_DATA, BUSY, VCM_VALID); end
        exp_vcm = 16'h0000;
        wq();
        RESET_N = 1'b1;
        wq();
        e = model_write(8'h18, 2, 24'h001000);
        write_txn(8'h18, 2, 24'h001000, 1'b1, acks);
        n_chk++; if (acks[2:0] !== e[2:0] || VCM_DATA !== 16'h0010) begin n_fail++; $display("FAIL rst_recover: got acks=%b vcm=%h want 111/0010", acks[2:0], VCM_DATA); end
    endtask

    task automatic test_random();
        logic [3:0] acks, e;
        logic [7:0] ab;
        logic [6:0] a;
        logic [23:0] d;
        logic [31:0] got;
        logic aa, rel;
        int n, rn, r0;
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = 7'($urandom_range(0, 127));
                if (a == 7'h0C) a = 7'h0D;
                ab = {a, 1'b0};
            end else ab = 8'h18;
            n  = $urandom_range(1, 3);
            d  = 24'($urandom);
            r0 = vld_rise;
            e  = model_write(ab, n, d);
            write_txn(ab, n, d, 1'b1, acks);
            n_chk++; if (acks !== e) begin n_fail++; $display("FAIL rand_acks[%0d]: got %b want %b", it, acks, e); end
            n_chk++; if (VCM_DATA !== exp_vcm || vld_rise - r0 != ((e[0] && n >= 2) ? 1 : 0)) begin n_fail++; $display("FAIL rand_vcm[%0d]: got %h pulses=%0d want %h", it, VCM_DATA, vld_rise - r0, exp_vcm); end
            rn = $urandom_range(1, 3);
            read_txn(rn, aa, got, rel);
            n_chk++; if (aa !== 1'b1 || got !== model_read(rn) || rel !== 1'b1) begin n_fail++; $display("FAIL rand_read[%0d]: got ack=%b data=%h rel=%b want 1/%h/1", it, aa, got, rel, model_read(rn)); end
        end
        n_chk++; if (vld_rise != exp_vld || vld_hi != exp_vld) begin n_fail++; $display("FAIL valid_total: got pulses=%0d cycles=%0d want %0d", vld_rise, vld_hi, exp_vld); end
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_write();
        test_wrong_addr();
        test_read_back();
        test_trunc_overlong();
        test_repeated_start();
        test_reset_mid_ack();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vcm_i2c_target.md
# vcm_i2c_target

Synthesizable I2C target that emulates the voice-coil-motor driver (DW9714/AD5820-class) addressed by the camera's auto-focus VCM writer. It sits on the SCL/SDA pair as the responder. It accepts the two-byte position word the focus controller writes each frame and exposes it as the lens position. It answers read-back transactions so write-read-write test mode can be closed in simulation and on a loopback board without the physical lens module.

## Interface
Parameters:
- DEV_ADDR, 7'h0C, 7-bit target address; write byte 0x18, read byte 0x19.

Ports (one clock; reset is asynchronous and active-low):
- CLK_50  in  1  system clock. All logic is synchronous to it; SCL/SDA are sampled, not used as clocks.
- RESET_N  in  1  asynchronous active-low reset.
- SCL  in  1  I2C clock from the initiator; the target never stretches it.
- SDA  inout  1  open-drain data line. Driven 1'b0 or 1'bz only, never 1'b1.
- VCM_DATA  out  16  last committed word: {PD, FLAG, D9..D0, S3..S0}.
- POSITION  out  10  VCM_DATA[13:4].
- POWER_DOWN  out  1  VCM_DATA[15].
- VCM_VALID  out  1  one-cycle pulse when VCM_DATA updates.
- BUSY  out  1  high from START to STOP while this target is addressed.

## Operation
- **Input conditioning.** SCL and SDA each pass through a 2-flop synchronizer plus one history flop.
- **Edge and condition detection** (all on synchronized signals):
  - SCL rise/fall.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- **Bit timing.** Data bits are sampled on SCL rise. The target changes its SDA drive only on SCL fall.
- **States:** IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_MACK, IGNORE.
  - IDLE: on START → ADDR, bit counter = 0.
  - ADDR: shift 8 bits MSB-first. On the 8th SCL rise, compare [7:1] to DEV_ADDR.
    - Match → ADDR_ACK.
    - Mismatch → IGNORE.
  - ADDR_ACK: pull SDA low for the 9th SCL pulse, then release on the following SCL fall.
    - R/W = 0 → WR_BYTE, byte index = 0.
    - R/W = 1 → RD_BYTE, byte index = 0, shift register loaded with VCM_DATA[15:8].
  - WR_BYTE: shift 8 bits → WR_ACK.
    - Byte index 0 goes to the pending high byte.
    - Byte index 1 goes to the pending low byte.
  - WR_ACK:
    - Index 0 or 1: ACK.
    - On the ACK of index 1, commit {high, low} to VCM_DATA and pulse VCM_VALID.
    - Index ≥ 2: NACK (SDA released), data discarded, next state IGNORE.
  - RD_BYTE: drive the shift-register MSB on each SCL fall. Drive 0 as a low pull; drive 1 as release.
  - RD_MACK: sample SDA on the 9th SCL rise.
    - ACK (0) → RD_BYTE with the other byte loaded (high/low alternate; wraps high→low→high).
    - NACK → IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- **Global events.**
  - START in any state → ADDR (repeated start). A pending uncommitted write byte is discarded.
  - STOP in any state → IDLE, SDA released, pending byte discarded.
- **Write commit rule.** A write commits only after both data bytes are ACKed. A transaction stopped after one data byte leaves VCM_DATA unchanged.
- **BUSY.** Set on entering ADDR_ACK with a match; cleared on STOP or on a START whose address mismatches.

## Timing
- **Reset values:** VCM_DATA = 16'h0000, POSITION = 0, POWER_DOWN = 0, VCM_VALID = 0, BUSY = 0, SDA = z, state = IDLE.
- **Reset mid-transaction:** immediately releases SDA. The bus recovers at the next START.
- **Detection latency:** a pin edge is detected 3 CLK_50 cycles after it occurs. The SDA drive change is registered 1 cycle later, i.e. ≤ 4 cycles after the SCL pin falls.
- **Bus timing requirements:** the initiator must hold SCL low ≥ 8 CLK_50 cycles and SDA setup ≥ 4 cycles. 400 kHz and slower satisfy both.
- **Commit timing:** VCM_VALID is high for exactly 1 cycle, on the cycle VCM_DATA takes the new value, which is the SCL-fall cycle that begins the 2nd data-byte ACK. POSITION and POWER_DOWN are combinational views of VCM_DATA.
- **Simultaneous START and SCL edge:** cannot occur by definition. The SDA-while-SCL-high test takes priority over bit shifting.

## Test plan
- **Basic write:** START, 0x18, 0x0F, 0xF0, STOP.
  - Expect ACK on all three bytes.
  - VCM_DATA = 16'h0FF0, POSITION = 10'h0FF, POWER_DOWN = 0.
  - Exactly one VCM_VALID pulse.
- **Wrong address:** START, 0x1A, 0x12, 0x34, STOP.
  - SDA never driven low.
  - VCM_DATA unchanged; no VCM_VALID pulse; BUSY stays 0.
- **Read-back:** after 0x0FF0 has been written, START, 0x19, master ACKs 3 bytes then NACKs the 4th.
  - Bytes read are 0x0F, 0xF0, 0x0F, 0xF0.
  - SDA released after the NACK.
- **Truncated and overlong writes:**
  - START, 0x18, 0x80, STOP → VCM_DATA unchanged.
  - START, 0x18, 0x80, 0x10, 0x55 → third data byte NACKed; VCM_DATA = 16'h8010, POWER_DOWN = 1.
- **Repeated start:** START, 0x18, 0x01, 0x23, Sr, 0x19, read 2 bytes.
  - VCM_DATA = 16'h0123 after the write.
  - Read returns 0x01, 0x23.
- **Reset mid-ACK:** assert RESET_N low while the target pulls SDA low during the address ACK.
  - SDA = z within the same cycle.
  - All outputs return to reset values.
  - A following full write of 0x18, 0x00, 0x10 commits 16'h0010.
